// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding and constants for the instruction fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} ifu_state_t;
  localparam logic [31:0] IFU_NOP = 32'h0000_0000;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifu_next_pc.sv
// ifu_next_pc: next-PC select (jr > jump/jal > taken branch > pc+4); IFU_MISALIGN_TRAP_EN keeps jr low bits
module ifu_next_pc (
  input  logic [31:0] i_pc,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_rs,
  input  logic        i_jr,
  input  logic        i_jmp,
  input  logic        i_jal,
  input  logic        i_branch,
  input  logic        i_nbranch,
  input  logic        i_zero,
  output logic [31:0] o_pc4,
  output logic [31:0] o_next_pc
);
  logic [31:0] w_jr_target;
  logic [31:0] w_br_target;
  logic        w_taken;
  assign o_pc4 = i_pc + 32'd4;
`ifdef IFU_MISALIGN_TRAP_EN
  assign w_jr_target = i_rs;
`else
  assign w_jr_target = i_rs & 32'hFFFF_FFFC;
`endif
  assign w_br_target = o_pc4 + {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
  assign w_taken = (i_branch & i_zero) | (i_nbranch & ~i_zero);
  // priority mux over the four possible successors
  always_comb begin
    o_next_pc = i_jr ? w_jr_target :
                (i_jmp | i_jal) ? {o_pc4[31:28], i_imm26, 2'b00} :
                w_taken ? w_br_target : o_pc4;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches words over req/ready+valid, holds them until retired; IFU_MISALIGN_TRAP_EN adds a misaligned-jr trap
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int          ADDR_WIDTH = 14
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  output logic                  oImemReq,
  output logic [ADDR_WIDTH-1:0] oImemAddr,
  input  logic                  iImemReady,
  input  logic                  iImemValid,
  input  logic [31:0]           iImemData,
  output logic [31:0]           oInstructionFetched,
  output logic                  oInstructionValid,
  output logic [31:0]           oPc,
  output logic [31:0]           oPcPlus4,
  input  logic                  iCpuAdvance,
  input  logic                  iJr,
  input  logic                  iJmp,
  input  logic                  iJal,
  input  logic                  iBranch,
  input  logic                  iNBranch,
  input  logic                  iZero,
  input  logic [31:0]           iRsValue,
  output logic                  oFault
);
  ifu_state_t  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc4;
  ifu_next_pc u_next_pc (
    .i_pc      (r_pc),
    .i_imm26   (r_instr[25:0]),
    .i_rs      (iRsValue),
    .i_jr      (iJr),
    .i_jmp     (iJmp),
    .i_jal     (iJal),
    .i_branch  (iBranch),
    .i_nbranch (iNBranch),
    .i_zero    (iZero),
    .o_pc4     (w_pc4),
    .o_next_pc (w_next_pc)
  );
`ifdef IFU_MISALIGN_TRAP_EN
  logic r_fault;
  logic w_misalign;
  assign w_misalign = iJr & |iRsValue[1:0];
  assign oFault = r_fault;
`else
  assign oFault = 1'b0;
`endif
  assign oImemReq = r_req;
  assign oImemAddr = r_pc[ADDR_WIDTH+1:2];
  assign oInstructionFetched = r_instr;
  assign oInstructionValid = r_valid;
  assign oPc = r_pc;
  assign oPcPlus4 = w_pc4;
  // fetch FSM: request, await response, hold word until the core retires it; outputs registered alongside state
  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      r_state <= S_REQ;
      r_pc <= RESET_PC;
      r_instr <= IFU_NOP;
      r_req <= 1'b0;
      r_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          r_state <= (r_req && iImemReady) ? S_WAIT : S_REQ;
          r_req <= ~(r_req && iImemReady);
        end
        S_WAIT: if (iImemValid) begin
          r_state <= S_HOLD;
          r_instr <= iImemData;
          r_valid <= 1'b1;
        end
        S_HOLD: if (iCpuAdvance) begin
          r_pc <= w_next_pc;
          r_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
          r_fault <= w_misalign;
          r_state <= w_misalign ? S_FAULT : S_REQ;
          r_req <= ~w_misalign;
`else
          r_state <= S_REQ;
          r_req <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Supplies the 32-bit instruction word consumed by the CPU core and owns the program counter.
- Issues word reads to instruction memory over a req/ready + valid handshake.
- Holds the fetched word stable until the core retires it, then computes the next PC from jump/branch controls and requests the next word.
- Sits between the instruction memory and the core's controller/decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_WIDTH, 14, instruction-memory word-address width (oImemAddr = PC[ADDR_WIDTH+1:2]).

Ports:
- iCpuClock  in  1  sole clock, rising edge.
- iCpuReset  in  1  synchronous, active-high reset.
- oImemReq  out  1  read request to instruction memory.
- oImemAddr  out  ADDR_WIDTH  word address of request.
- iImemReady  in  1  memory accepts request this cycle.
- iImemValid  in  1  response data valid.
- iImemData  in  32  response instruction word.
- oInstructionFetched  out  32  instruction presented to core.
- oInstructionValid  out  1  oInstructionFetched is valid.
- oPc  out  32  PC of presented instruction.
- oPcPlus4  out  32  oPc+4, used as the jal link value.
- iCpuAdvance  in  1  core retires presented instruction this cycle.
- iJr, iJmp, iJal, iBranch, iNBranch  in  1 each  controller decode of presented instruction.
- iZero  in  1  ALU zero flag for the presented instruction.
- iRsValue  in  32  register rs value (jr target).
- oFault  out  1  misaligned jr trap (IFU_MISALIGN_TRAP_EN only; else tied 0).

Behaviour:
- Reset (any state): PC=RESET_PC, state=S_REQ. Outputs: oImemReq=0, oInstructionValid=0, oInstructionFetched=32'h0 (NOP), oFault=0. A response outstanding at reset is discarded.
- States:
  - S_REQ: oImemReq=1, oImemAddr=PC[ADDR_WIDTH+1:2]. On iImemReady -> S_WAIT.
  - S_WAIT: oImemReq=0. On iImemValid, latch iImemData -> S_HOLD.
  - S_HOLD: oInstructionValid=1; the word stays stable. On iCpuAdvance, PC<=next_pc -> S_REQ.
  - S_FAULT: only with the option enabled.
- iImemValid outside S_WAIT is ignored.
- iImemReady and iImemValid in the same cycle while in S_REQ: only the accept counts; data is expected no earlier than the next cycle.
- Latency: with a memory that is always ready and returns data one cycle later, advance-to-valid is 3 cycles (S_REQ, S_WAIT, S_HOLD).
- iCpuAdvance outside S_HOLD is ignored. Controls and iRsValue are sampled only on the advance cycle.
- next_pc priority:
  - iJr: iRsValue.
  - else iJmp|iJal: {pc4[31:28], instr[25:0], 2'b00}.
  - else taken branch, where taken=(iBranch&iZero)|(iNBranch&~iZero): pc4 + (sext(instr[15:0])<<2).
  - else pc4.
  - pc4=PC+4.
- All adds are 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0.
- Word addresses beyond 2^ADDR_WIDTH alias by truncation.
- Jr target bits [1:0] are cleared before loading PC when the option is disabled.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined: on advance with iJr=1 and iRsValue[1:0]!=0, go to S_FAULT, oFault=1, no further requests, oInstructionValid=0. PC holds the faulting target unchanged. Only reset exits S_FAULT.
- Undefined: no S_FAULT state, oFault constant 0, low bits silently cleared.

Decomposition:
- Package ifu_pkg: state encoding (S_REQ, S_WAIT, S_HOLD, S_FAULT), NOP constant 32'h0, default RESET_PC.
- One combinational sub-module, ifu_next_pc: next-PC mux plus branch/jump target arithmetic. Kept separate so it can be tested on its own.

Test Plan:
- Reset then zero-latency memory returning 32'h2008_0005 at word 0 -> after 3 cycles oInstructionValid=1, oPc=0, oPcPlus4=4; iCpuAdvance -> next oImemAddr=1.
- Presented word 32'h1000_FFFF at PC=0x10 with iBranch=1, iZero=1, advance -> next PC=0x10; with iZero=0 -> PC=0x14.
- Presented word 32'h0C00_0040 at PC=0x3000_0000 with iJal=1 -> PC=0x3000_0100, oPcPlus4 was 0x3000_0004.
- iJr=1, iRsValue=0x0000_0102, advance -> trap build: oFault=1, oImemReq held 0; non-trap build: PC=0x100.
- iImemReady held low 5 cycles, then a stray iImemValid during S_REQ -> request persists with the same address and the stray data is not latched.
- Assert iCpuReset during S_WAIT, then iImemValid next cycle -> data ignored, PC=RESET_PC, request reissued at word 0.
